hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. Every cycle it decides, from hazard and memory-status inputs, whether the PC advances and what each pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) does: load, hold or flush. It drives the 2-bit `sf` port of each register and keeps two saturating performance counters. A small FSM discards an instruction fetch that was already in flight when a taken branch resolved.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_rs1_addr` in 5: rs1 of the instruction in ID.
- `id_rs2_addr` in 5: rs2 of the instruction in ID.
- `id_rs1_used` in 1: the ID instruction reads rs1.
- `id_rs2_used` in 1: the ID instruction reads rs2.
- `ex_mem_r` in 1: the instruction in EX is a load.
- `ex_rd_addr` in 5: rd of the instruction in EX.
- `ex_branch_taken` in 1: EX redirects the PC (taken branch or jump).
- `if_busy` in 1: instruction memory has not returned the fetch for the current PC.
- `mem_busy` in 1: data memory has not completed the access in MEM.
- `pc_write` out 1: PC register load enable.
- `if_id_sf`, `id_ex_sf`, `ex_mem_sf`, `mem_wb_sf` out 2 each: sf[0] flushes the register to its bubble; sf[1] holds it. 2'b00 means load.
- `stall_cnt` out CNT_W: cycles with `pc_write`=0.
- `flush_cnt` out CNT_W: accepted branch redirects.

## Operation
- States: RUN and FLUSH_PEND. Reset state is RUN.
- Outputs are combinational from state and inputs.
- Per-cycle priority, first match wins:
  1. **Data-memory freeze** (`mem_busy`=1): `pc_write`=0; IF_ID, ID_EX and EX_MEM get 2'b10; MEM_WB gets 2'b01. `ex_branch_taken` is ignored, because the branch stays held in EX and re-presents after the freeze.
  2. **Branch redirect** (`ex_branch_taken`=1): `pc_write`=1 (PC takes the target even if `if_busy`); IF_ID and ID_EX get 2'b01; EX_MEM and MEM_WB get 2'b00. `flush_cnt` increments. Next state is FLUSH_PEND if `if_busy`=1, else RUN.
  3. **Load-use** (`ex_mem_r` and `ex_rd_addr`≠0 and ((`id_rs1_used` and rs1 matches) or (`id_rs2_used` and rs2 matches))): `pc_write`=0; IF_ID gets 2'b10; ID_EX gets 2'b01; EX_MEM and MEM_WB get 2'b00.
  4. **Fetch wait** (`if_busy`=1 in RUN): `pc_write`=0; IF_ID gets 2'b01; all others get 2'b00.
  5. **Otherwise**: `pc_write`=1 and every sf is 2'b00.
- FLUSH_PEND, when none of rules 1–3 applies: `pc_write`=0; IF_ID gets 2'b01; all others get 2'b00.
  - While `if_busy`=1, stay in FLUSH_PEND.
  - When `if_busy`=0, the returned wrong-path instruction is discarded (IF_ID still gets 2'b01) and the state goes to RUN. The PC already holds the target, so the refetch starts next cycle.
- FLUSH_PEND with rule 1 (freeze) active: freeze outputs apply. If `if_busy`=0 in that cycle, the state still goes to RUN.
- FLUSH_PEND with rule 2 (new redirect) active: handled exactly as in RUN.
- Counters: `stall_cnt` increments on every cycle with `pc_write`=0. Both counters saturate at all-ones and never wrap.

## Timing
- Reset (`rst` low) asynchronously forces:
  - state RUN and both counters 0;
  - `pc_write`=0 and all four sf outputs = 2'b01 for as long as `rst` is low.
- Reset asserted mid-FLUSH_PEND abandons the pending discard.
- Decision latency is zero cycles: outputs settle in the same cycle as the inputs and are sampled by the pipeline registers at the next rising edge.
- State and counters update on the rising edge.
- Load-use costs exactly 1 bubble. A branch costs 2 bubbles plus the remaining `if_busy` cycles and 1 discard cycle.
- `ex_rd_addr`=0 never raises a load-use stall.

## Test plan
- **Load-use, rs1:** `ex_mem_r`=1, `ex_rd_addr`=5, `id_rs1_addr`=5, `id_rs1_used`=1, other inputs 0 → one cycle of `pc_write`=0, if_id 10, id_ex 01; `stall_cnt` 0→1. Repeat with `ex_rd_addr`=0 → no stall.
- **Branch, fetch idle:** `ex_branch_taken`=1, `if_busy`=0 → `pc_write`=1, if_id 01, id_ex 01; `flush_cnt`=1; state stays RUN.
- **Branch during fetch:** `ex_branch_taken`=1 with `if_busy`=1 held 3 more cycles → FLUSH_PEND for 3 cycles (`pc_write`=0, if_id 01). The cycle `if_busy` drops, if_id is 01; the state is RUN after that edge; `stall_cnt`=4.
- **Freeze vs branch:** `mem_busy`=1 for 2 cycles with `ex_branch_taken`=1 → if_id/id_ex/ex_mem 10, mem_wb 01, `flush_cnt` unchanged. When `mem_busy` drops, the redirect fires once and `flush_cnt`=1.
- **Saturation and reset:** CNT_W=4, 20 stall cycles → `stall_cnt`=15. Pull `rst` low mid-FLUSH_PEND → counters 0, all sf 01, `pc_write`=0 immediately; after release the state is RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage core.
//   Each cycle it decides whether the PC advances and whether each pipeline
//   register loads, holds or flushes. It also keeps two saturating
//   performance counters. A two-state FSM discards a fetch that was still
//   in flight when a taken branch redirected the PC.
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   id_rs1_addr/id_rs2_addr   source registers of the ID instruction
//   id_rs1_used/id_rs2_used   ID instruction actually reads rs1/rs2
//   ex_mem_r, ex_rd_addr      EX instruction is a load, and its rd
//   ex_branch_taken           EX redirects the PC
//   if_busy, mem_busy         instruction / data memory not yet done
//   pc_write                  PC load enable
//   *_sf                      per-register control: [0] flush, [1] hold
//   stall_cnt, flush_cnt      cycles without PC advance, accepted redirects
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_r,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             if_busy,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic [1:0]       if_id_sf,
    output logic [1:0]       id_ex_sf,
    output logic [1:0]       ex_mem_sf,
    output logic [1:0]       mem_wb_sf,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] SF_LOAD  = 2'b00;
    localparam logic [1:0] SF_FLUSH = 2'b01;
    localparam logic [1:0] SF_HOLD  = 2'b10;

    typedef enum logic {RUN, FLUSH_PEND} state_t;

    state_t state, state_nxt;
    logic   load_use;
    logic   redirect;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_r && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        pc_write  = 1'b1;
        if_id_sf  = SF_LOAD;
        id_ex_sf  = SF_LOAD;
        ex_mem_sf = SF_LOAD;
        mem_wb_sf = SF_LOAD;
        redirect  = 1'b0;
        // Outside a new redirect the only thing keeping us in FLUSH_PEND is
        // the wrong-path fetch still being outstanding.
        state_nxt = (state == FLUSH_PEND && if_busy) ? FLUSH_PEND : RUN;

        if (!rst) begin
            // Pipeline is flushed and PC parked for the whole reset.
            pc_write  = 1'b0;
            if_id_sf  = SF_FLUSH;
            id_ex_sf  = SF_FLUSH;
            ex_mem_sf = SF_FLUSH;
            mem_wb_sf = SF_FLUSH;
            state_nxt = RUN;
        end else if (mem_busy) begin
            // Freeze: everything upstream of MEM holds, MEM_WB gets a bubble.
            // A taken branch in EX is held and re-presents after the freeze.
            pc_write  = 1'b0;
            if_id_sf  = SF_HOLD;
            id_ex_sf  = SF_HOLD;
            ex_mem_sf = SF_HOLD;
            mem_wb_sf = SF_FLUSH;
        end else if (ex_branch_taken) begin
            // PC takes the target even if a fetch is outstanding; that fetch
            // is then discarded from FLUSH_PEND.
            redirect  = 1'b1;
            if_id_sf  = SF_FLUSH;
            id_ex_sf  = SF_FLUSH;
            state_nxt = if_busy ? FLUSH_PEND : RUN;
        end else if (load_use) begin
            pc_write  = 1'b0;
            if_id_sf  = SF_HOLD;
            id_ex_sf  = SF_FLUSH;
        end else if (state == FLUSH_PEND) begin
            // Either still waiting, or the wrong-path word arrives this cycle
            // and must not be captured.
            pc_write  = 1'b0;
            if_id_sf  = SF_FLUSH;
        end else if (if_busy) begin
            pc_write  = 1'b0;
            if_id_sf  = SF_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && flush_cnt != '1)  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
